digit_glyph_fetch: RTL and testbench

- Read-side client of the digits glyph ROM. Accepts a digit request (0-9) and walks the 15 ROM addresses of that digit's 3x5 glyph. Packs the returned pixels into a 15-bit bitmap and hands it to the display/overlay logic over a valid/ready handshake.
- Hides ROM layout and read latency from the renderer, so the ROM can be combinational or block-registered.

---
 rtl/digit_glyph_fetch.sv | 150 +++++++++++++++
 tb/tb_digit_glyph_fetch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_glyph_fetch.sv
// digit_glyph_fetch: walks the 15 ROM words of a 3x5 digit glyph and packs
// them into a bitmap. The ROM may be combinational or registered; the read
// latency is a build-time parameter, so the renderer never sees ROM timing.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its payload stable
// until that edge. req_ready is high only in IDLE. bmp_valid is high only in
// DONE, where bmp_bits/bmp_err stay frozen until bmp_ready is seen.
module digit_glyph_fetch #(
    parameter int GLYPH_W   = 3,
    parameter int GLYPH_H   = 5,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int READ_LAT  = 1,
    parameter int MAX_DIGIT = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_digit,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [DATA_W-1:0]          rom_data,
    output logic                       bmp_valid,
    input  logic                       bmp_ready,
    output logic [GLYPH_W*GLYPH_H-1:0] bmp_bits,
    output logic                       bmp_err,
    output logic [1:0]                 o_dbg_state
);

    localparam int NPIX = GLYPH_W * GLYPH_H;
    localparam logic [3:0] LAST_IDX = 4'(NPIX - 1);
    localparam logic [3:0] MAX_D    = 4'(MAX_DIGIT);
    localparam logic [1:0] LAT      = 2'(READ_LAT);
    localparam bit         HAS_LAT  = (READ_LAT > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]        r_digit;   // digit latched at accept
    logic [3:0]        r_cyc;     // issue index, 0..14
    logic [3:0]        r_cap;     // next pixel index to capture
    logic [1:0]        r_skip;    // cycles left before the first sample lands
    logic [NPIX-1:0]   r_bits;
    logic              r_err;

    logic              w_accept;
    logic              w_legal;
    logic              w_walk;
    logic              w_capture;
    logic              w_last_cap;
    logic [3:0]        w_issue;
    logic [ADDR_W-1:0] w_digit_ext;
    logic [ADDR_W-1:0] w_base;

    assign w_accept    = req_valid && req_ready;
    assign w_legal     = (req_digit <= MAX_D);
    assign w_walk      = (r_state == S_FETCH) || (r_state == S_DRAIN);
    // A sample is captured every walk cycle once the first ROM word has had
    // READ_LAT cycles to arrive; the pixel index runs behind the issue index.
    assign w_capture   = w_walk && (r_skip == 2'd0);
    assign w_last_cap  = w_capture && (r_cap == LAST_IDX);
    // DRAIN keeps the last address on the bus.
    assign w_issue     = (r_state == S_FETCH) ? r_cyc : LAST_IDX;
    // base = digit*15 without a multiplier.
    assign w_digit_ext = ADDR_W'(r_digit);
    assign w_base      = (w_digit_ext << 4) - w_digit_ext;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_legal ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                if (r_cyc == LAST_IDX) w_next = HAS_LAT ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                if (w_last_cap) w_next = S_DONE;
            end
            S_DONE: begin
                if (bmp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        req_ready   = (r_state == S_IDLE) && rst_n;
        bmp_valid   = (r_state == S_DONE);
        rom_addr    = w_walk ? (w_base + ADDR_W'(w_issue)) : '0;
        bmp_bits    = r_bits;
        bmp_err     = r_err;
        o_dbg_state = r_state;
    end

    // Datapath: digit latch, issue/capture counters and bitmap assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
            r_cyc   <= 4'd0;
            r_cap   <= 4'd0;
            r_skip  <= 2'd0;
            r_bits  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_digit <= req_digit;
                r_cyc   <= 4'd0;
                r_cap   <= 4'd0;
                r_skip  <= LAT;
                if (w_legal) begin
                    r_err  <= 1'b0;
                end else begin
                    r_bits <= '0;
                    r_err  <= 1'b1;
                end
            end
            if (r_state == S_FETCH && r_cyc != LAST_IDX) begin
                r_cyc <= r_cyc + 4'd1;
            end
            if (w_walk && r_skip != 2'd0) begin
                r_skip <= r_skip - 2'd1;
            end
            if (w_capture) begin
                r_bits[r_cap] <= |rom_data;
                r_cap         <= r_cap + 4'd1;
            end
            if (r_state == S_DONE && bmp_ready) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digit_glyph_fetch.sv
// Bench for digit_glyph_fetch: a READ_LAT=1 instance carries the directed and
// random scenarios; READ_LAT=0 and READ_LAT=2 instances check latency scaling.
// Cycle numbering: the accept edge is cycle 0 and "cycle k" is the clock
// period following the k-th edge after it.
module tb_digit_glyph_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_digit = 4'd0;

    logic        req_valid_1 = 1'b0, bmp_ready_1 = 1'b1;
    logic        req_ready_1, bmp_valid_1, bmp_err_1;
    logic [7:0]  rom_addr_1, rom_data_1;
    logic [14:0] bmp_bits_1;
    logic [1:0]  dbg_1;

    logic        req_valid_0 = 1'b0, req_valid_2 = 1'b0, bmp_ready_02 = 1'b1;
    logic        req_ready_0, bmp_valid_0, bmp_err_0;
    logic        req_ready_2, bmp_valid_2, bmp_err_2;
    logic [7:0]  rom_addr_0, rom_data_0, rom_addr_2, rom_data_2;
    logic [14:0] bmp_bits_0, bmp_bits_2;
    logic [1:0]  dbg_0, dbg_2;

    logic [7:0]  rom [0:255];
    logic [7:0]  q1, q2a, q2b;
    logic [14:0] glyph [0:9];
    logic [15:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / ROM models ----------------
    always #5 clk = ~clk;

    assign rom_data_0 = rom[rom_addr_0];
    always @(posedge clk) q1 <= rom[rom_addr_1];
    assign rom_data_1 = q1;
    always @(posedge clk) begin
        q2a <= rom[rom_addr_2];
        q2b <= q2a;
    end
    assign rom_data_2 = q2b;

    digit_glyph_fetch #(.READ_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_digit(req_digit), .rom_addr(rom_addr_1), .rom_data(rom_data_1),
        .bmp_valid(bmp_valid_1), .bmp_ready(bmp_ready_1), .bmp_bits(bmp_bits_1),
        .bmp_err(bmp_err_1), .o_dbg_state(dbg_1));

    digit_glyph_fetch #(.READ_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_0), .req_ready(req_ready_0),
        .req_digit(req_digit), .rom_addr(rom_addr_0), .rom_data(rom_data_0),
        .bmp_valid(bmp_valid_0), .bmp_ready(bmp_ready_02), .bmp_bits(bmp_bits_0),
        .bmp_err(bmp_err_0), .o_dbg_state(dbg_0));

    digit_glyph_fetch #(.READ_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_2), .req_ready(req_ready_2),
        .req_digit(req_digit), .rom_addr(rom_addr_2), .rom_data(rom_data_2),
        .bmp_valid(bmp_valid_2), .bmp_ready(bmp_ready_02), .bmp_bits(bmp_bits_2),
        .bmp_err(bmp_err_2), .o_dbg_state(dbg_2));

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted; on return the bench is in cycle 0.
    task automatic do_accept(input logic [3:0] d, output bit ok);
        ok = 1'b0;
        req_digit   = d;
        req_valid_1 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready_1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        req_valid_1 = 1'b0;
    endtask

    // Advance until bmp_valid is seen; k is the cycle index when it is.
    task automatic wait_valid(input int start, output int k);
        k = start;
        while (!bmp_valid_1 && k < start + 100) begin
            tick();
            k++;
        end
    endtask

    // Reference: base = 15*digit, glyph pixel i at base+i; illegal -> err, 0.
    function automatic logic [15:0] model(input logic [3:0] d);
        if (d > 4'd9) return {1'b1, 15'd0};
        return {1'b0, glyph[d]};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if (req_ready_1 !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_low got %b want 0", req_ready_1);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({req_ready_1, rom_addr_1, bmp_valid_1, bmp_bits_1, bmp_err_1} !== {1'b1, 8'h00, 1'b0, 15'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values got rdy=%b addr=%h v=%b bits=%h err=%b want 1/00/0/0000/0",
                     req_ready_1, rom_addr_1, bmp_valid_1, bmp_bits_1, bmp_err_1);
        end
    endtask

    task automatic test_digit0();
        bit ok; int k; int bad; logic [7:0] bad_addr;
        bmp_ready_1 = 1'b1;
        do_accept(4'd0, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL d0_accept got timeout want accept"); end
        bad = -1; bad_addr = 8'h00;
        for (int i = 0; i < 15; i++) begin
            if (bad < 0 && rom_addr_1 !== 8'(i)) begin bad = i; bad_addr = rom_addr_1; end
            tick();
        end
        n_vec++;
        if (bad >= 0) begin
            n_err++; $display("FAIL d0_addr_walk got %h want %h", bad_addr, 8'(bad));
        end
        wait_valid(15, k);
        n_vec++;
        if (k !== 16) begin n_err++; $display("FAIL d0_latency got %0d want 16", k); end
        n_vec++;
        if ({bmp_err_1, bmp_bits_1} !== 16'h2B6A) begin
            n_err++; $display("FAIL d0_bits got err=%b bits=%h want 0/2b6a", bmp_err_1, bmp_bits_1);
        end
        tick();
        n_vec++;
        if ({req_ready_1, bmp_valid_1} !== 2'b10) begin
            n_err++; $display("FAIL d0_return_idle got rdy=%b v=%b want 1/0", req_ready_1, bmp_valid_1);
        end
    endtask

    task automatic test_back_to_back();
        int k; int busy_bad; int bad; logic [7:0] bad_addr;
        bmp_ready_1 = 1'b1;
        req_digit   = 4'd1;
        req_valid_1 = 1'b1;
        k = 0;
        while (!req_ready_1 && k < 50) begin tick(); k++; end
        tick();                      // accept edge for digit 1
        req_digit = 4'd9;            // must be ignored by the digit-1 fetch
        busy_bad = 0;
        k = 0;
        while (!bmp_valid_1 && k < 100) begin
            if (req_ready_1 !== 1'b0) busy_bad++;
            tick(); k++;
        end
        n_vec++;
        if (busy_bad != 0) begin n_err++; $display("FAIL b2b_ready_busy got %0d high cycles want 0", busy_bad); end
        n_vec++;
        if ({bmp_err_1, bmp_bits_1} !== 16'h7492) begin
            n_err++; $display("FAIL b2b_bits_d1 got err=%b bits=%h want 0/7492", bmp_err_1, bmp_bits_1);
        end
        n_vec++;
        if (req_ready_1 !== 1'b0) begin n_err++; $display("FAIL b2b_no_turnaround got %b want 0", req_ready_1); end
        tick();
        n_vec++;
        if (req_ready_1 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after got %b want 1", req_ready_1); end
        tick();                      // second accept, digit 9
        req_valid_1 = 1'b0;
        bad = -1; bad_addr = 8'h00;
        for (int i = 0; i < 15; i++) begin
            if (bad < 0 && rom_addr_1 !== 8'(135 + i)) begin bad = i; bad_addr = rom_addr_1; end
            tick();
        end
        n_vec++;
        if (bad >= 0) begin
            n_err++; $display("FAIL b2b_addr_d9 got %h want %h", bad_addr, 8'(135 + bad));
        end
        wait_valid(15, k);
        n_vec++;
        if ({bmp_err_1, bmp_bits_1} !== 16'h49AA) begin
            n_err++; $display("FAIL b2b_bits_d9 got err=%b bits=%h want 0/49aa", bmp_err_1, bmp_bits_1);
        end
        tick();
    endtask

    task automatic test_illegal();
        bit ok; int k;
        bmp_ready_1 = 1'b1;
        do_accept(4'd11, ok);
        // The error result is presented directly in the cycle after accept.
        n_vec++;
        if ({bmp_valid_1, bmp_err_1, bmp_bits_1, rom_addr_1} !== {1'b1, 1'b1, 15'h0, 8'h00}) begin
            n_err++;
            $display("FAIL illegal_result got v=%b err=%b bits=%h addr=%h want 1/1/0000/00",
                     bmp_valid_1, bmp_err_1, bmp_bits_1, rom_addr_1);
        end
        tick();
        n_vec++;
        if ({bmp_valid_1, bmp_err_1, req_ready_1} !== 3'b001) begin
            n_err++; $display("FAIL illegal_clear got v=%b err=%b rdy=%b want 0/0/1", bmp_valid_1, bmp_err_1, req_ready_1);
        end
        do_accept(4'd3, ok);
        wait_valid(0, k);
        n_vec++;
        if ({bmp_err_1, bmp_bits_1} !== model(4'd3)) begin
            n_err++; $display("FAIL illegal_then_legal got %h want %h", {bmp_err_1, bmp_bits_1}, model(4'd3));
        end
        tick();
    endtask

    task automatic test_stall();
        bit ok; int k; int bad; int after;
        bmp_ready_1 = 1'b0;
        do_accept(4'd0, ok);
        wait_valid(0, k);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({bmp_valid_1, bmp_bits_1, req_ready_1} !== {1'b1, 15'h2B6A, 1'b0}) bad++;
            tick();
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        n_vec++;
        if ({bmp_valid_1, bmp_bits_1} !== {1'b1, 15'h2B6A}) begin
            n_err++; $display("FAIL stall_before_release got v=%b bits=%h want 1/2b6a", bmp_valid_1, bmp_bits_1);
        end
        bmp_ready_1 = 1'b1;
        tick();
        after = 0;
        for (int i = 0; i < 4; i++) begin
            if (bmp_valid_1) after++;
            tick();
        end
        n_vec++;
        if (after != 0) begin n_err++; $display("FAIL stall_single_transfer got %0d extra valid cycles want 0", after); end
    endtask

    task automatic test_reset_mid();
        bit ok; int k; int seen;
        bmp_ready_1 = 1'b1;
        do_accept(4'd5, ok);
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        n_vec++;
        if ({req_ready_1, rom_addr_1, bmp_valid_1, bmp_bits_1, bmp_err_1} !== {1'b0, 8'h00, 1'b0, 15'h0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_values got rdy=%b addr=%h v=%b bits=%h err=%b want 0/00/0/0000/0",
                     req_ready_1, rom_addr_1, bmp_valid_1, bmp_bits_1, bmp_err_1);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bmp_valid_1) seen++;
            tick();
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL midreset_no_result got %0d valid cycles want 0", seen); end
        do_accept(4'd5, ok);
        wait_valid(0, k);
        n_vec++;
        if ({k, bmp_err_1, bmp_bits_1} !== {32'd16, model(4'd5)}) begin
            n_err++; $display("FAIL midreset_fresh got lat=%0d val=%h want 16/%h", k, {bmp_err_1, bmp_bits_1}, model(4'd5));
        end
        tick();
    endtask

    task automatic test_latency();
        int lat0; int lat2; logic [14:0] b0; logic [14:0] b2;
        lat0 = -1; lat2 = -1; b0 = '0; b2 = '0;
        req_digit   = 4'd0;
        req_valid_0 = 1'b1;
        req_valid_2 = 1'b1;
        tick();                      // both are idle, so this edge accepts
        req_valid_0 = 1'b0;
        req_valid_2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bmp_valid_0 && lat0 < 0) begin lat0 = k; b0 = bmp_bits_0; end
            if (bmp_valid_2 && lat2 < 0) begin lat2 = k; b2 = bmp_bits_2; end
            tick();
        end
        n_vec++;
        if (lat0 !== 15 || b0 !== 15'h2B6A) begin
            n_err++; $display("FAIL lat0 got lat=%0d bits=%h want 15/2b6a", lat0, b0);
        end
        n_vec++;
        if (lat2 !== 17 || b2 !== 15'h2B6A) begin
            n_err++; $display("FAIL lat2 got lat=%0d bits=%h want 17/2b6a", lat2, b2);
        end
    endtask

    task automatic test_random();
        bit ok; int k; int stall; logic [3:0] d; logic [15:0] exp_v;
        for (int n = 0; n < 40; n++) begin
            d = 4'($urandom_range(0, 15));
            stall = $urandom_range(0, 3);
            exp_q.push_back(model(d));
            bmp_ready_1 = (stall == 0);
            do_accept(d, ok);
            req_digit = 4'($urandom_range(0, 15));
            wait_valid(0, k);
            n_vec++;
            if (k !== ((d > 4'd9) ? 0 : 16)) begin
                n_err++; $display("FAIL rand_latency got %0d for digit %0d", k, d);
            end
            for (int s = 0; s < stall; s++) tick();
            bmp_ready_1 = 1'b1;
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({bmp_valid_1, bmp_err_1, bmp_bits_1} !== {1'b1, exp_v}) begin
                n_err++;
                $display("FAIL rand_result digit %0d got v=%b val=%h want 1/%h", d, bmp_valid_1, {bmp_err_1, bmp_bits_1}, exp_v);
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        glyph[0] = 15'h2B6A; glyph[1] = 15'h7492; glyph[2] = 15'h73A7;
        glyph[3] = 15'h79A7; glyph[4] = 15'h49ED; glyph[5] = 15'h79CF;
        glyph[6] = 15'h7BCF; glyph[7] = 15'h4927; glyph[8] = 15'h7BEF;
        glyph[9] = 15'h49AA;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom_range(0, 255));
        for (int g = 0; g < 10; g++) begin
            for (int i = 0; i < 15; i++) begin
                rom[g * 15 + i] = glyph[g][i] ? 8'($urandom_range(1, 255)) : 8'h00;
            end
        end
        test_reset();
        test_digit0();
        test_back_to_back();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

endmodule
